// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with MIPS-style HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one step per clock, 33 busy cycles per op.
module mul_div_unit #(
  parameter logic [2:0] OP_MULT  = 3'd0,
  parameter logic [2:0] OP_MULTU = 3'd1,
  parameter logic [2:0] OP_DIV   = 3'd2,
  parameter logic [2:0] OP_DIVU  = 3'd3,
  parameter logic [2:0] OP_MTHI  = 3'd4,
  parameter logic [2:0] OP_MTLO  = 3'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] in1_q, in2_q;
  logic [31:0] acc_hi_q, acc_lo_q;
  logic [5:0]  cnt_q;

  logic        start_arith, start_signed;
  logic        signed_q, is_div_q;
  logic [31:0] in1_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod, prod_fix;
  logic        neg_res;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    start_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    start_signed = (op == OP_MULT) || (op == OP_DIV);
    in1_mag      = (start_signed && in1[31]) ? (~in1 + 32'd1) : in1;

    signed_q = (op_q == OP_MULT) || (op_q == OP_DIV);
    is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
    b_mag    = (signed_q && in2_q[31]) ? (~in2_q + 32'd1) : in2_q;

    // Multiply: acc_hi is the partial product, acc_lo the multiplier shifting out.
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag} : 33'd0);
    // Divide: acc_hi is the remainder, acc_lo the dividend shifting into the quotient.
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_mag};

    neg_res  = signed_q && (in1_q[31] ^ in2_q[31]);
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_res ? (~prod + 64'd1) : prod;

    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (is_div_q) begin
      if (in2_q == 32'd0) begin
        res_lo = 32'hFFFF_FFFF;
        res_hi = in1_q;
      end else begin
        res_lo = neg_res ? (~acc_lo_q + 32'd1) : acc_lo_q;
        res_hi = (signed_q && in1_q[31]) ? (~acc_hi_q + 32'd1) : acc_hi_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= 3'd0;
      in1_q    <= 32'd0;
      in2_q    <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      cnt_q    <= 6'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (start_arith) begin
              op_q     <= op;
              in1_q    <= in1;
              in2_q    <= in2;
              acc_hi_q <= 32'd0;
              acc_lo_q <= in1_mag;
              cnt_q    <= 6'd0;
              busy     <= 1'b1;
              state_q  <= StRun;
            end else if (op == OP_MTHI) begin
              hi <= in1;
            end else if (op == OP_MTLO) begin
              lo <= in1;
            end
          end
        end
        StRun: begin
          if (is_div_q) begin
            acc_hi_q <= div_diff[33] ? div_shift[31:0] : div_diff[31:0];
            acc_lo_q <= {acc_lo_q[30:0], ~div_diff[33]};
          end else begin
            acc_hi_q <= mul_sum[32:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[31:1]};
          end
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          hi      <= res_hi;
          lo      <= res_lo;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed HI/LO results.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] in1, in2;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges after the accepting edge until busy drops (33 expected).
  task automatic wait_done(input int already, output int n);
    n = already;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    start = 1'b1; op = o; in1 = a; in2 = b;
    tick();
    start = 1'b0; in1 = ~a; in2 = ~b; op = o ^ 3'd1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(0, n);
    check({tag, "_cycles"}, n, 32'd33);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    tick();
    check({tag, "_done_off"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    // Reset must win over a simultaneous MTHI.
    reset = 1'b1; start = 1'b1; op = 3'd4; in1 = 32'h0000_1234; in2 = 32'd0;
    tick();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("rst_hold_hi", hi, 32'd0);

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_nn",   3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0,         32'd30);
    run_op("div_m7_2",  3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2",  3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_op("divu_100",  3'd3, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("divu_zero", 3'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_zero",  3'd2, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

    // MTHI while idle: visible after one edge, no busy/done.
    start = 1'b1; op = 3'd4; in1 = 32'hA5A5_A5A5;
    tick();
    start = 1'b0;
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_lo", lo, 32'h8000_0000);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);

    // Opcodes 6 and 7 do nothing.
    start = 1'b1; op = 3'd6; in1 = 32'h1111_1111; in2 = 32'd3;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, 32'hA5A5_A5A5);
    check("nop_lo", lo, 32'h8000_0000);

    // MTLO five cycles into a MULT is ignored.
    start = 1'b1; op = 3'd0; in1 = 32'd6; in2 = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; op = 3'd5; in1 = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    check("mtlo_busy_lo", lo, 32'h8000_0000);
    wait_done(5, n);
    check("mtlo_cycles", n, 32'd33);
    check("mtlo_done", {31'd0, done}, 32'd1);
    check("mtlo_hi", hi, 32'd0);
    check("mtlo_lo", lo, 32'd42);
    tick();

    // Reset aborts a DIVU at cycle 10; nothing written, then an immediate MULTU.
    start = 1'b1; op = 3'd3; in1 = 32'd1000; in2 = 32'd3;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    run_op("multu_3x4", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter OP_MULT, default 3'd0: signed multiply.
REQ-002 Parameter OP_MULTU, default 3'd1: unsigned multiply.
REQ-003 Parameter OP_DIV, default 3'd2: signed divide.
REQ-004 Parameter OP_DIVU, default 3'd3: unsigned divide.
REQ-005 Parameter OP_MTHI, default 3'd4: load HI from in1.
REQ-006 Parameter OP_MTLO, default 3'd5: load LO from in1.
REQ-007 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port start, input, 1: request strobe, sampled each rising edge.
REQ-010 Port op, input, 3: operation code; op values 6 and 7 SHALL act as no-ops.
REQ-011 Port in1, input, 32: multiplicand, dividend, or MTHI/MTLO data.
REQ-012 Port in2, input, 32: multiplier or divisor.
REQ-013 Port busy, output, 1: high while a multiply or divide is in progress.
REQ-014 Port done, output, 1: one-cycle pulse when HI/LO receive a mult/div result.
REQ-015 Port hi, output, 32: HI register contents.
REQ-016 Port lo, output, 32: LO register contents.

Function
REQ-017 FSM states: IDLE, RUN, FINISH; busy SHALL be 1 exactly in RUN and FINISH.
REQ-018 IDLE, start=1, op in {0..3}: latch op, in1 and in2; clear the 6-bit iteration counter; go to RUN.
REQ-019 IDLE, start=1, op=OP_MTHI: hi <= in1 at that edge; state stays IDLE; no busy, no done.
REQ-020 IDLE, start=1, op=OP_MTLO: lo <= in1 at that edge; state stays IDLE; no busy, no done.
REQ-021 start while busy=1: ignored entirely, including MTHI/MTLO; latched operands unchanged.
REQ-022 RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); after 32 steps, go to FINISH.
REQ-023 FINISH: write hi/lo; done=1 for that edge's following cycle; return to IDLE.
REQ-024 Latency: start sampled at edge E0 -> busy=1 for 33 cycles; hi/lo updated and done=1 after edge E33; busy=0 after E33.
REQ-025 Multiply: 64-bit product; hi = bits[63:32], lo = bits[31:0].
REQ-026 MULTU: operands are unsigned; MULT: operands are two's complement, via magnitudes plus final negation.
REQ-027 Divide: lo = quotient, truncated toward zero; hi = remainder; the remainder sign SHALL follow the dividend (MIPS semantics).
REQ-028 DIVU: operands are unsigned; DIV: magnitudes are used, then signs are fixed.
REQ-029 Divide by zero (either divide op): lo = 32'hFFFFFFFF, hi = in1 as latched; same 33-cycle latency.
REQ-030 DIV of 32'h80000000 by 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
REQ-031 hi/lo SHALL hold their value except for writes by REQ-019, REQ-020 and REQ-023.
REQ-032 Changes on in1, in2 or op during RUN SHALL NOT affect the result.
REQ-033 done and busy SHALL be registered outputs, free of glitches from the inputs.

Reset
REQ-034 reset=1 at a rising edge: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, internal operand registers 0.
REQ-035 reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL NOT write hi/lo.
REQ-036 The cycle after reset deasserts, start SHALL be accepted normally.

Verification
REQ-037 MULTU, in1=32'hFFFFFFFF, in2=32'hFFFFFFFF -> after 33 busy cycles: hi=32'hFFFFFFFE, lo=32'h00000001, done pulses once.
REQ-038 MULT, in1=-3 (32'hFFFFFFFD), in2=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-039 DIV, in1=-7, in2=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU, in1=100, in2=7 -> lo=14, hi=2.
REQ-040 DIVU, in2=0, in1=32'h12345678 -> lo=32'hFFFFFFFF, hi=32'h12345678; DIV 32'h80000000 by -1 -> lo=32'h80000000, hi=0.
REQ-041 MTHI 32'hA5A5A5A5 while idle -> hi updates the next cycle with busy=0; MTLO issued 5 cycles into a MULT -> ignored, and the final lo is the product.
REQ-042 reset asserted at cycle 10 of a DIVU -> busy=0, hi=lo=0 the next cycle, no done pulse; a new MULTU 3x4 then yields lo=12, hi=0.
